// File: rtl/sr_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sr_deserializer_if
//  Description : Serial stream, frame selects and parallel latch outputs
//                of the shift-register deserializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sr_deserializer_if #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
);
    logic                  SER_IN;
    logic                  SER_VALID;
    logic                  SELSTAT;
    logic                  SELDYN;
    logic [SIZESRSTAT-1:0] STATLATCH;
    logic [SIZESRDYN-1:0]  DYNLATCH;
    logic                  STAT_DONE;
    logic                  DYN_DONE;
    logic                  FRAME_ERR;
    logic                  BUSY;

    // Stream source / latch consumer side
    modport master (
        output SER_IN, SER_VALID, SELSTAT, SELDYN,
        input  STATLATCH, DYNLATCH, STAT_DONE, DYN_DONE, FRAME_ERR, BUSY
    );

    // Deserializer side
    modport slave (
        input  SER_IN, SER_VALID, SELSTAT, SELDYN,
        output STATLATCH, DYNLATCH, STAT_DONE, DYN_DONE, FRAME_ERR, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/sr_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : sr_deserializer
//  Description : Rebuilds static and dynamic shift-register words from a
//                one-bit MSB-first stream framed by SELSTAT/SELDYN, and
//                transfers each completed frame into a parallel latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_deserializer #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    sr_deserializer_if.slave    bus
);

    localparam int CW = $clog2(SIZESRSTAT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RX_STAT = 2'd1;
    localparam logic [1:0] S_RX_DYN  = 2'd2;

    localparam logic [CW-1:0] c_STAT_LAST = CW'(SIZESRSTAT - 1);
    localparam logic [CW-1:0] c_DYN_LAST  = CW'(SIZESRDYN - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    // Only N-1 bits are stored: the final bit goes straight from SER_IN
    // into the latch, so the shifter never needs to hold a full word.
    logic [SIZESRSTAT-2:0] r_shift_stat;
    logic [SIZESRDYN-2:0]  r_shift_dyn;
    logic [SIZESRSTAT-1:0] r_statlatch;
    logic [SIZESRDYN-1:0]  r_dynlatch;
    logic                  r_selstat_q;
    logic                  r_seldyn_q;
    logic                  r_stat_done;
    logic                  r_dyn_done;
    logic                  r_frame_err;
    logic                  w_shift_stat;
    logic                  w_shift_dyn;
    logic                  w_stat_done;
    logic                  w_dyn_done;
    logic                  w_err;
    logic                  w_busy;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and datapath control decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_stat = 1'b0;
        w_shift_dyn  = 1'b0;
        w_stat_done  = 1'b0;
        w_dyn_done   = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.SELSTAT && bus.SELDYN) begin
                    w_err = 1'b1;
                end else if (bus.SELSTAT && !r_selstat_q) begin
                    // Only a fresh rising select starts a frame
                    w_state_nxt = S_RX_STAT;
                    if (bus.SER_VALID) begin
                        w_shift_stat = 1'b1;
                        w_cnt_nxt    = CW'(1);
                    end
                end else if (bus.SELDYN && !r_seldyn_q) begin
                    w_state_nxt = S_RX_DYN;
                    if (bus.SER_VALID) begin
                        w_shift_dyn = 1'b1;
                        w_cnt_nxt   = CW'(1);
                    end
                end
            end
            S_RX_STAT: begin
                // Conflict beats completion; completion beats a falling select
                if (bus.SELDYN) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (bus.SER_VALID && (r_cnt == c_STAT_LAST)) begin
                    w_stat_done = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (!bus.SELSTAT) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (bus.SER_VALID) begin
                    w_shift_stat = 1'b1;
                    w_cnt_nxt    = r_cnt + CW'(1);
                end
            end
            S_RX_DYN: begin
                if (bus.SELSTAT) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (bus.SER_VALID && (r_cnt == c_DYN_LAST)) begin
                    w_dyn_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (!bus.SELDYN) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (bus.SER_VALID) begin
                    w_shift_dyn = 1'b1;
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State-derived outputs
    always_comb begin
        w_busy = (r_state == S_RX_STAT) || (r_state == S_RX_DYN);
    end

    // Shifters, bit counter, latches, select history and one-cycle pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt        <= '0;
            r_shift_stat <= '0;
            r_shift_dyn  <= '0;
            r_statlatch  <= '0;
            r_dynlatch   <= '0;
            r_selstat_q  <= 1'b0;
            r_seldyn_q   <= 1'b0;
            r_stat_done  <= 1'b0;
            r_dyn_done   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_selstat_q <= bus.SELSTAT;
            r_seldyn_q  <= bus.SELDYN;
            r_stat_done <= w_stat_done;
            r_dyn_done  <= w_dyn_done;
            r_frame_err <= w_err;
            if (w_shift_stat) begin
                r_shift_stat <= {r_shift_stat[SIZESRSTAT-3:0], bus.SER_IN};
            end
            if (w_shift_dyn) begin
                r_shift_dyn <= {r_shift_dyn[SIZESRDYN-3:0], bus.SER_IN};
            end
            if (w_stat_done) begin
                r_statlatch <= {r_shift_stat, bus.SER_IN};
            end
            if (w_dyn_done) begin
                r_dynlatch <= {r_shift_dyn, bus.SER_IN};
            end
        end
    end

    assign bus.STATLATCH = r_statlatch;
    assign bus.DYNLATCH  = r_dynlatch;
    assign bus.STAT_DONE = r_stat_done;
    assign bus.DYN_DONE  = r_dyn_done;
    assign bus.FRAME_ERR = r_frame_err;
    assign bus.BUSY      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_sr_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_deserializer
//  Description : Directed self-checking bench for sr_deserializer with a
//                scoreboard of expected latch words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_deserializer;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    sr_deserializer_if #(.SIZESRSTAT(88), .SIZESRDYN(16)) bus ();

    sr_deserializer #(.SIZESRSTAT(88), .SIZESRDYN(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_stat = 0;
    int n_dyn  = 0;
    int n_err  = 0;

    logic [87:0] exp_stat[$];
    logic [15:0] exp_dyn[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample just after the edge and score any DONE pulse
    task automatic tick();
        logic [87:0] es;
        logic [15:0] ed;
        @(posedge CLK);
        #1;
        if (bus.STAT_DONE) begin
            n_stat++;
            chk("stat_done_expected", 128'(exp_stat.size() != 0), 128'(1));
            if (exp_stat.size() != 0) begin
                es = exp_stat.pop_front();
                chk("statlatch_sb", 128'(bus.STATLATCH), 128'(es));
            end
        end
        if (bus.DYN_DONE) begin
            n_dyn++;
            chk("dyn_done_expected", 128'(exp_dyn.size() != 0), 128'(1));
            if (exp_dyn.size() != 0) begin
                ed = exp_dyn.pop_front();
                chk("dynlatch_sb", 128'(bus.DYNLATCH), 128'(ed));
            end
        end
        if (bus.FRAME_ERR) n_err++;
    endtask

    task automatic drive(input logic ss, input logic sd, input logic v, input logic b);
        bus.SELSTAT   = ss;
        bus.SELDYN    = sd;
        bus.SER_VALID = v;
        bus.SER_IN    = b;
        tick();
    endtask

    // Send data[first] down to data[first-count+1], MSB first, with an
    // optional stall on every stall_every-th cycle
    task automatic send_bits(input bit is_stat, input logic [87:0] data,
                             input int first, input int count, input int stall_every);
        int idx = first;
        int cyc = 0;
        logic [87:0] d;
        d = data;
        while (idx > first - count) begin
            if (stall_every > 0 && (cyc % stall_every) == stall_every - 1) begin
                drive(is_stat, !is_stat, 1'b0, 1'b0);
            end else begin
                drive(is_stat, !is_stat, 1'b1, d[idx]);
                idx--;
            end
            cyc++;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    localparam logic [87:0] c_P1 = 88'h0123456789ABCDEF012345;
    localparam logic [87:0] c_P2 = 88'hFEDCBA9876543210C0FFEE;
    localparam logic [87:0] c_P3 = 88'h5A5A5A5A0F0F0F0F3C3C3C;
    localparam logic [87:0] c_P4 = 88'h8000000000000000000001;
    localparam logic [87:0] c_D1 = 88'h00000000000000000A5C3;
    localparam logic [87:0] c_D2 = 88'h0000000000000000001E7;

    int e0, s0, d0;

    initial begin
        bus.SELSTAT = 0; bus.SELDYN = 0; bus.SER_VALID = 0; bus.SER_IN = 0;

        // Reset state
        tick(); tick();
        chk("rst_statlatch", 128'(bus.STATLATCH), 128'(0));
        chk("rst_dynlatch",  128'(bus.DYNLATCH),  128'(0));
        chk("rst_outputs", 128'({bus.STAT_DONE, bus.DYN_DONE, bus.FRAME_ERR, bus.BUSY}), 128'(0));
        RST = 1'b0;
        idle();

        // Dynamic frame 0xA5C3
        exp_dyn.push_back(16'hA5C3);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk("dyn_busy", 128'(bus.BUSY), 128'(1));
        send_bits(1'b0, c_D1, 14, 15, 0);
        chk("dyn_done_pulse", 128'(bus.DYN_DONE), 128'(1));
        chk("dyn_latch", 128'(bus.DYNLATCH), 128'(16'hA5C3));
        chk("dyn_busy_off", 128'(bus.BUSY), 128'(0));
        idle();
        chk("dyn_done_1cyc", 128'(bus.DYN_DONE), 128'(0));
        chk("dyn_stat_unch", 128'(bus.STATLATCH), 128'(0));
        chk("dyn_count", 128'(n_dyn), 128'(1));

        // Static frame with a stall every third cycle
        exp_stat.push_back(c_P1);
        s0 = n_stat;
        send_bits(1'b1, c_P1, 87, 88, 3);
        chk("stall_done", 128'(bus.STAT_DONE), 128'(1));
        idle();
        chk("stall_latch", 128'(bus.STATLATCH), 128'(c_P1));
        chk("stall_one_pulse", 128'(n_stat - s0), 128'(1));
        chk("stall_dyn_unch", 128'(bus.DYNLATCH), 128'(16'hA5C3));

        // Abort: select drops after 50 bits
        e0 = n_err;
        send_bits(1'b1, c_P2, 87, 50, 0);
        chk("abort_busy_mid", 128'(bus.BUSY), 128'(1));
        idle();
        chk("abort_err", 128'(bus.FRAME_ERR), 128'(1));
        chk("abort_busy", 128'(bus.BUSY), 128'(0));
        idle();
        chk("abort_err_1cyc", 128'(bus.FRAME_ERR), 128'(0));
        chk("abort_latch", 128'(bus.STATLATCH), 128'(c_P1));

        // Conflict in IDLE
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("cfl_idle_err", 128'(bus.FRAME_ERR), 128'(1));
        chk("cfl_idle_busy", 128'(bus.BUSY), 128'(0));
        idle();
        chk("cfl_idle_busy2", 128'(bus.BUSY), 128'(0));

        // Conflict during RX_STAT
        send_bits(1'b1, c_P2, 87, 30, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("cfl_rx_err", 128'(bus.FRAME_ERR), 128'(1));
        chk("cfl_rx_busy", 128'(bus.BUSY), 128'(0));
        idle();

        // Conflict on the final bit still aborts
        send_bits(1'b1, c_P2, 87, 87, 0);
        drive(1'b1, 1'b1, 1'b1, c_P2[0]);
        chk("cfl_final_err", 128'(bus.FRAME_ERR), 128'(1));
        chk("cfl_final_nodone", 128'(bus.STAT_DONE), 128'(0));
        idle();
        chk("cfl_latch", 128'(bus.STATLATCH), 128'(c_P1));
        chk("err_count", 128'(n_err - e0), 128'(4));

        // Select falling on the final bit still completes
        exp_stat.push_back(c_P4);
        send_bits(1'b1, c_P4, 87, 87, 0);
        drive(1'b0, 1'b0, 1'b1, c_P4[0]);
        chk("fall_final_done", 128'(bus.STAT_DONE), 128'(1));
        chk("fall_final_noerr", 128'(bus.FRAME_ERR), 128'(0));
        idle();

        // Asynchronous reset mid-frame after 40 bits
        send_bits(1'b1, c_P2, 87, 40, 0);
        #1;
        RST = 1'b1;
        bus.SELSTAT = 1'b0;
        #1;
        chk("arst_statlatch", 128'(bus.STATLATCH), 128'(0));
        chk("arst_dynlatch",  128'(bus.DYNLATCH),  128'(0));
        chk("arst_busy", 128'(bus.BUSY), 128'(0));
        idle();
        RST = 1'b0;
        idle();
        exp_stat.push_back(c_P3);
        s0 = n_stat;
        send_bits(1'b1, c_P3, 87, 88, 0);
        idle();
        chk("post_rst_latch", 128'(bus.STATLATCH), 128'(c_P3));
        chk("post_rst_one", 128'(n_stat - s0), 128'(1));

        // Back-to-back static then dynamic, first dyn bit in the IDLE cycle
        e0 = n_err; s0 = n_stat; d0 = n_dyn;
        exp_stat.push_back(c_P1);
        exp_dyn.push_back(16'h01E7);
        send_bits(1'b1, c_P1, 87, 88, 0);
        send_bits(1'b0, c_D2, 15, 16, 0);
        idle();
        chk("b2b_stat", 128'(bus.STATLATCH), 128'(c_P1));
        chk("b2b_dyn", 128'(bus.DYNLATCH), 128'(16'h01E7));
        chk("b2b_counts", 128'({n_stat - s0, n_dyn - d0}), 128'({32'd1, 32'd1}));
        chk("b2b_noerr", 128'(n_err - e0), 128'(0));

        // Every expected frame consumed
        chk("sb_empty", 128'(exp_stat.size() + exp_dyn.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_deserializer.md
Name: sr_deserializer

Overview:
- Receive-side counterpart of the shift-register serializer (generator).
- Takes the one-bit serial stream and rebuilds the static (88-bit) and dynamic (16-bit) shift-register words.
- Framing comes from the same SELSTAT/SELDYN select strobes produced by fsm_shiftRegs.
- Each completed frame is transferred into a parallel latch register. Aborted or ambiguous frames are flagged and discarded.

Parameters:
SIZESRSTAT, 88, static shift register length in bits
SIZESRDYN, 16, dynamic shift register length in bits

Ports:
CLK  input  1  system clock; all logic is on the rising edge
RST  input  1  asynchronous, active-high reset
SER_IN  input  1  serial data bit, MSB first
SER_VALID  input  1  SER_IN carries a valid bit this cycle
SELSTAT  input  1  static frame select; held high for the whole static frame
SELDYN  input  1  dynamic frame select; held high for the whole dynamic frame
STATLATCH  output  SIZESRSTAT  last complete static word (register)
DYNLATCH  output  SIZESRDYN  last complete dynamic word (register)
STAT_DONE  output  1  one-cycle pulse: STATLATCH was updated
DYN_DONE  output  1  one-cycle pulse: DYNLATCH was updated
FRAME_ERR  output  1  one-cycle pulse: frame aborted or selects conflicting
BUSY  output  1  high while in RX_STAT or RX_DYN

Behaviour:
- Reset (RST=1, asynchronous, any state):
  - State goes to IDLE; bit counter and both internal shift registers clear to 0.
  - STATLATCH=0, DYNLATCH=0; STAT_DONE, DYN_DONE, FRAME_ERR and BUSY are 0.
  - A frame in progress is lost. After RST falls, the next frame must start with a fresh select rising from IDLE.
- Bit counter: width $clog2(SIZESRSTAT+1); it is shared by both frame types.
- Shift rule: for each accepted bit, shift_x <= {shift_x[N-2:0], SER_IN}. The first bit received ends up in the MSB.
- IDLE:
  - SELSTAT=1 and SELDYN=0: go to RX_STAT.
  - SELDYN=1 and SELSTAT=0: go to RX_DYN.
  - On either entry, if SER_VALID=1 in that same cycle, the bit is captured as the first bit and the counter becomes 1; otherwise the counter becomes 0.
  - SELSTAT=1 and SELDYN=1: stay in IDLE, pulse FRAME_ERR, capture nothing.
  - Bits arriving while no select is high are ignored.
- RX_STAT:
  - Each cycle with SER_VALID=1 shifts one bit into shift_stat and increments the counter. SER_VALID=0 is a stall: no shift, no count.
  - Final bit is the valid cycle with counter==SIZESRSTAT-1. On that edge, STATLATCH <= {shift_stat[SIZESRSTAT-2:0], SER_IN}, STAT_DONE=1 for exactly the following cycle, and the state returns to IDLE.
  - If SELSTAT=0 or SELDYN=1 before the final bit: FRAME_ERR pulses for one cycle, the state returns to IDLE, and STATLATCH is unchanged.
  - SELSTAT still high after completion is not a new frame. A new frame requires SELSTAT to go low and then high again, so IDLE enters RX_STAT only on the 0→1 edge of the select (registered copy).
- RX_DYN: identical to RX_STAT using SIZESRDYN, shift_dyn, DYNLATCH, DYN_DONE and SELDYN. The abort conditions are SELDYN=0 or SELSTAT=1.
- Priority within one cycle:
  - The final bit completes even if the select falls in that same cycle; the completion is honoured.
  - A conflict while RX is active is an abort, even on the final-bit cycle.
- Latency: last bit sampled at edge k → latch valid after edge k, DONE pulse high during cycle k+1.
- The latches hold their value until the next successful frame of the same type. The static and dynamic latches are independent of each other.
- BUSY is combinational from the state: 1 in RX_STAT or RX_DYN.

Test Plan:
- Reset: assert RST mid-RX_STAT after 40 bits → all outputs 0 immediately (asynchronous); release, then send a full static frame → STAT_DONE pulses and STATLATCH matches that frame only.
- Dynamic frame: SELDYN=1, 16 continuous bits 0xA5C3 MSB first → DYNLATCH=16'hA5C3, DYN_DONE high for 1 cycle exactly 1 cycle after the 16th bit, STATLATCH unchanged.
- Static frame with stalls: 88 bits of pattern 88'h0123456789ABCDEF012345 with SER_VALID=0 inserted every 3rd cycle → STATLATCH equals the pattern, exactly one STAT_DONE pulse.
- Abort: SELSTAT drops after 50 bits → FRAME_ERR 1 cycle, STATLATCH keeps its previous value, BUSY=0 the next cycle.
- Conflict: SELSTAT=SELDYN=1 in IDLE → FRAME_ERR pulse, no state change. Raising SELDYN during RX_STAT → FRAME_ERR, no latch update.
- Back-to-back: a static frame followed immediately by a dynamic frame (SELSTAT falls, SELDYN rises the same cycle), with the first dynamic bit valid in the IDLE cycle → both latches correct, one STAT_DONE and one DYN_DONE, no FRAME_ERR.
